// File: rtl/nocft_congestion_monitor_pkg.sv
// Shared port indices, sizing constants and counter types for the NoC congestion monitor.
// The sizing constants live here so the counter/sum typedef widths always follow them.
`ifndef NOCFT_PORT_DEFINES
`define NOCFT_PORT_DEFINES
`define NORTH 0
`define EAST  1
`define SOUTH 2
`define WEST  3
`endif

package nocft_congestion_monitor_pkg;
  localparam int NUM_PORTS = 4;
  localparam int NV        = 2;
  localparam int BUF_DEPTH = 4;
  localparam int CONG_ON   = 2;
  localparam int CONG_OFF  = 4;
  localparam int STALL_LIM = 8;

  typedef logic [$clog2(BUF_DEPTH+1)-1:0]    credit_cnt_t;
  typedef logic [$clog2(NV*BUF_DEPTH+1)-1:0] port_free_t;
  typedef logic [$clog2(STALL_LIM+1)-1:0]    stall_cnt_t;
endpackage

// File: rtl/nocft_congestion_monitor_credit_port.sv
// One planar output port: per-VC credit counters, free-credit hysteresis,
// head-of-line stall timer and sticky credit error.
//
//   state     | meaning
//   HYST_LOW  | enough free credits downstream, no threshold congestion
//   HYST_HIGH | free credits fell to CONG_ON, held until they recover to CONG_OFF
module nocft_credit_port
  import nocft_congestion_monitor_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flit_sent,
  input  logic [NV-1:0] sent_vc,
  input  logic [NV-1:0] credit_ret,
  input  logic          port_req,
  input  logic [NV-1:0] req_vc,
  output logic          cong_next,
  output logic [NV-1:0] avail_next,
  output logic          cred_err
);
  typedef enum logic {HYST_LOW, HYST_HIGH} hyst_state_t;

  localparam credit_cnt_t CNT_MAX   = credit_cnt_t'(BUF_DEPTH);
  localparam stall_cnt_t  STALL_MAX = stall_cnt_t'(STALL_LIM);

  credit_cnt_t cnt_q [NV];
  credit_cnt_t cnt_d [NV];
  logic        err_d;
  port_free_t  free;
  hyst_state_t hyst_q, hyst_d;
  stall_cnt_t  stall_q, stall_d;
  logic [NV-1:0] cnt_zero;
  logic        stalled;

  // A send and a return on the same VC cancel; saturate and flag otherwise.
  always_comb begin
    err_d = cred_err;
    for (int v = 0; v < NV; v++) begin
      cnt_d[v] = cnt_q[v];
      if ((flit_sent && sent_vc[v]) && !credit_ret[v]) begin
        if (cnt_q[v] == '0) err_d = 1'b1;
        else                cnt_d[v] = cnt_q[v] - credit_cnt_t'(1);
      end else if (credit_ret[v] && !(flit_sent && sent_vc[v])) begin
        if (cnt_q[v] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[v] = cnt_q[v] + credit_cnt_t'(1);
      end
      avail_next[v] = (cnt_d[v] != '0);
      cnt_zero[v]   = (cnt_q[v] == '0);
    end
  end

  always_comb begin
    free = '0;
    for (int v = 0; v < NV; v++) free = free + port_free_t'(cnt_q[v]);
  end

  always_comb begin
    hyst_d = hyst_q;
    case (hyst_q)
      HYST_LOW:  if (free <= port_free_t'(CONG_ON))  hyst_d = HYST_HIGH;
      HYST_HIGH: if (free >= port_free_t'(CONG_OFF)) hyst_d = HYST_LOW;
      default:   hyst_d = HYST_LOW;
    endcase
  end

  always_comb begin
    stalled = port_req && ((req_vc & cnt_zero) != '0);
    stall_d = '0;
    if (stalled) stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + stall_cnt_t'(1);
    cong_next = (hyst_d == HYST_HIGH) || (stall_d == STALL_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) cnt_q[v] <= CNT_MAX;
      hyst_q   <= HYST_LOW;
      stall_q  <= '0;
      cred_err <= 1'b0;
    end else begin
      for (int v = 0; v < NV; v++) cnt_q[v] <= cnt_d[v];
      hyst_q   <= hyst_d;
      stall_q  <= stall_d;
      cred_err <= err_d;
    end
  end
endmodule

// File: rtl/nocft_congestion_monitor.sv
// Per-router congestion monitor: four independent credit ports plus the
// registered congestion and credit-available outputs seen by the routing unit.
module nocft_congestion_monitor
  import nocft_congestion_monitor_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          flit_sent,
  input  logic [NUM_PORTS-1:0][NV-1:0]  sent_vc,
  input  logic [NUM_PORTS-1:0][NV-1:0]  credit_ret,
  input  logic [NUM_PORTS-1:0]          port_req,
  input  logic [NUM_PORTS-1:0][NV-1:0]  req_vc,
  output logic [NUM_PORTS-1:0]          congestion,
  output logic [NUM_PORTS-1:0][NV-1:0]  credit_avail,
  output logic [NUM_PORTS-1:0]          cred_err
);
  logic [NUM_PORTS-1:0]         cong_next;
  logic [NUM_PORTS-1:0][NV-1:0] avail_next;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    nocft_credit_port u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .flit_sent  (flit_sent[p]),
      .sent_vc    (sent_vc[p]),
      .credit_ret (credit_ret[p]),
      .port_req   (port_req[p]),
      .req_vc     (req_vc[p]),
      .cong_next  (cong_next[p]),
      .avail_next (avail_next[p]),
      .cred_err   (cred_err[p])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      congestion   <= '0;
      credit_avail <= '1;
    end else begin
      congestion   <= cong_next;
      credit_avail <= avail_next;
    end
  end
endmodule

// File: tb/tb_nocft_congestion_monitor.sv
// Directed plus randomized bench for nocft_congestion_monitor against a
// cycle-level reference model built from the credit/hysteresis/stall rules.
module tb_nocft_congestion_monitor;
  localparam int NV = 2, BUF_DEPTH = 4, CONG_ON = 2, CONG_OFF = 4, STALL_LIM = 8;
  localparam int PN = 0, PE = 1, PS = 2, PW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]         flit_sent = '0;
  logic [3:0][NV-1:0] sent_vc = '0;
  logic [3:0][NV-1:0] credit_ret = '0;
  logic [3:0]         port_req = '0;
  logic [3:0][NV-1:0] req_vc = '0;
  logic [3:0]         congestion;
  logic [3:0][NV-1:0] credit_avail;
  logic [3:0]         cred_err;

  nocft_congestion_monitor dut (
    .clk(clk), .rst_n(rst_n), .flit_sent(flit_sent), .sent_vc(sent_vc),
    .credit_ret(credit_ret), .port_req(port_req), .req_vc(req_vc),
    .congestion(congestion), .credit_avail(credit_avail), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int m_cnt [4][NV];
  bit m_err [4];
  bit m_hyst[4];
  int m_stall[4];
  bit m_cong[4];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flit_sent = '0; sent_vc = '0; credit_ret = '0; port_req = '0; req_vc = '0;
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    int nc[4][NV];
    int free;
    bit dec, inc, stalled;
    for (int p = 0; p < 4; p++) begin
      if (!rst_n) begin
        for (int v = 0; v < NV; v++) nc[p][v] = BUF_DEPTH;
        m_err[p] = 0; m_hyst[p] = 0; m_stall[p] = 0; m_cong[p] = 0;
      end else begin
        free = 0;
        stalled = 0;
        for (int v = 0; v < NV; v++) begin
          free += m_cnt[p][v];
          if (port_req[p] && req_vc[p][v] && m_cnt[p][v] == 0) stalled = 1;
          dec = flit_sent[p] && sent_vc[p][v];
          inc = credit_ret[p][v];
          nc[p][v] = m_cnt[p][v];
          if (dec && !inc) begin
            if (m_cnt[p][v] == 0) m_err[p] = 1; else nc[p][v] = m_cnt[p][v] - 1;
          end else if (inc && !dec) begin
            if (m_cnt[p][v] == BUF_DEPTH) m_err[p] = 1; else nc[p][v] = m_cnt[p][v] + 1;
          end
        end
        if (!m_hyst[p] && free <= CONG_ON) m_hyst[p] = 1;
        else if (m_hyst[p] && free >= CONG_OFF) m_hyst[p] = 0;
        m_stall[p] = stalled ? ((m_stall[p] + 1 > STALL_LIM) ? STALL_LIM : m_stall[p] + 1) : 0;
        m_cong[p] = m_hyst[p] || (m_stall[p] == STALL_LIM);
      end
    end
    for (int p = 0; p < 4; p++)
      for (int v = 0; v < NV; v++) m_cnt[p][v] = nc[p][v];
  endtask

  task automatic step();
    logic [3:0] exp_c, exp_e;
    logic [3:0][NV-1:0] exp_a;
    model_edge();
    for (int p = 0; p < 4; p++) begin
      exp_c[p] = m_cong[p];
      exp_e[p] = m_err[p];
      for (int v = 0; v < NV; v++) exp_a[p][v] = (m_cnt[p][v] != 0);
    end
    @(posedge clk);
    #1;
    check("model_congestion", 32'(congestion), 32'(exp_c));
    check("model_cred_err", 32'(cred_err), 32'(exp_e));
    check("model_credit_avail", 32'(credit_avail), 32'(exp_a));
  endtask

  initial begin
    for (int p = 0; p < 4; p++) for (int v = 0; v < NV; v++) m_cnt[p][v] = BUF_DEPTH;

    // Reset held two cycles, then release
    rst_n = 1'b0; idle();
    step(); step();
    rst_n = 1'b1;
    step();
    check("reset_congestion", 32'(congestion), 32'h0);
    check("reset_cred_err", 32'(cred_err), 32'h0);
    check("reset_credit_avail", 32'(credit_avail), 32'hFF);

    // Six EAST sends, three per VC: free drops to 2
    for (int i = 0; i < 6; i++) begin
      idle(); flit_sent[PE] = 1'b1; sent_vc[PE] = (i % 2) ? 2'b10 : 2'b01;
      step();
    end
    check("thr_not_yet", 32'(congestion), 32'h0);
    idle(); step();
    check("thr_east_asserted", 32'(congestion), 32'b0010);

    // Hysteresis: free=3 holds, free=4 releases one cycle later
    idle(); credit_ret[PE] = 2'b01; step();
    idle(); step();
    check("hyst_hold_at_3", 32'(congestion[PE]), 32'h1);
    idle(); credit_ret[PE] = 2'b10; step();
    check("hyst_still_high", 32'(congestion[PE]), 32'h1);
    idle(); step();
    check("hyst_release_at_4", 32'(congestion), 32'h0);

    // Simultaneous send and return on WEST VC1
    idle(); flit_sent[PW] = 1'b1; sent_vc[PW] = 2'b10; credit_ret[PW] = 2'b10;
    step();
    check("simul_no_err", 32'(cred_err), 32'h0);
    check("simul_avail", 32'(credit_avail[PW]), 32'b11);
    idle(); step();
    check("simul_no_cong", 32'(congestion[PW]), 32'h0);

    // NORTH VC0 drained, then stall on it
    for (int i = 0; i < 4; i++) begin
      idle(); flit_sent[PN] = 1'b1; sent_vc[PN] = 2'b01; step();
    end
    check("drain_avail", 32'(credit_avail[PN]), 32'b10);
    check("drain_no_cong", 32'(congestion), 32'h0);
    idle(); port_req[PN] = 1'b1; req_vc[PN] = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) check("stall_before_lim", 32'(congestion[PN]), 32'h0);
      if (i == 8) check("stall_at_lim", 32'(congestion[PN]), 32'h1);
    end
    step();
    check("stall_saturated", 32'(congestion[PN]), 32'h1);
    idle(); step();
    check("stall_dropped", 32'(congestion[PN]), 32'h0);

    // Underflow on NORTH VC0, overflow on SOUTH VC0
    idle(); flit_sent[PN] = 1'b1; sent_vc[PN] = 2'b01; step();
    check("underflow_err", 32'(cred_err), 32'b0001);
    check("underflow_avail", 32'(credit_avail[PN]), 32'b10);
    idle(); credit_ret[PS] = 2'b01; step();
    check("overflow_err", 32'(cred_err), 32'b0101);
    idle(); step(); step();
    check("err_sticky", 32'(cred_err), 32'b0101);
    check("overflow_hold", 32'(credit_avail[PS]), 32'b11);

    // Random traffic with a reset asserted mid-stream
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++) begin
        flit_sent[p]  = ($urandom_range(0, 2) == 0);
        sent_vc[p]    = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        for (int v = 0; v < NV; v++) credit_ret[p][v] = ($urandom_range(0, 3) == 0);
        port_req[p]   = ($urandom_range(0, 1) != 0);
        req_vc[p]     = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      end
      rst_n = (i != 200);
      step();
      if (i == 200) begin
        check("midreset_congestion", 32'(congestion), 32'h0);
        check("midreset_cred_err", 32'(cred_err), 32'h0);
        check("midreset_credit_avail", 32'(credit_avail), 32'hFF);
      end
    end
    rst_n = 1'b1; idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
